// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32I pipeline: opcodes, ALU codes, mux selects, E-stage bundle.
// The ALU imports alu_op_e from here so that decode and execute agree on one code map.
package riscv_ctrl_pkg;

  localparam int ALU_W = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0010, ALU_OR   = 4'b0011,
    ALU_SLTU = 4'b0100, ALU_SLT  = 4'b0101, ALU_XOR  = 4'b0110, ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000, ALU_SRA  = 4'b1001, ALU_BEQ  = 4'b1010, ALU_BNE  = 4'b1011,
    ALU_BLT  = 4'b1100, ALU_BGE  = 4'b1101, ALU_BLTU = 4'b1110, ALU_BGEU = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    SRCA_RS1 = 2'b00, SRCA_ZERO = 2'b01, SRCA_PC = 2'b10
  } src_a_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    alu_op_e     alu_control;
    src_a_sel_e  src_a_sel;
    logic        alu_src;
    logic        reg_write;
    logic        mem_write;
    result_src_e result_src;
    logic        branch;
    logic        jump;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        illegal;
    logic        valid;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // funct3 -> ALU op for R-type and I-ALU; alt selects sub/sra.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I instruction -> control decoder feeding the ID/EX register.
module id_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [2:0]  imm_src
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl        = CTRL_BUBBLE;
    imm_src     = IMM_I;
    legal       = 1'b0;
    ctrl.rs1    = instr[19:15];
    ctrl.rs2    = instr[24:20];
    ctrl.rd     = instr[11:7];
    ctrl.funct3 = funct3;
    ctrl.valid  = 1'b1;

    case (opcode)
      OP_R: begin
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        ctrl.alu_control = alu_from_funct3(funct3, funct7[5]);
        ctrl.reg_write   = 1'b1;
      end
      OP_I: begin
        // Only shifts constrain imm[11:5]; addi never becomes sub.
        if (funct3 == 3'b001)
          legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101)
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else
          legal = 1'b1;
        ctrl.alu_control = alu_from_funct3(funct3, funct3 == 3'b101 && funct7[5]);
        ctrl.alu_src     = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OP_LOAD: begin
        legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.reg_write  = 1'b1;
      end
      OP_STORE: begin
        legal = funct3 inside {3'b000, 3'b001, 3'b010};
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        imm_src        = IMM_S;
      end
      OP_BRANCH: begin
        legal = !(funct3 inside {3'b010, 3'b011});
        case (funct3)
          3'b000:  ctrl.alu_control = ALU_BEQ;
          3'b001:  ctrl.alu_control = ALU_BNE;
          3'b100:  ctrl.alu_control = ALU_BLT;
          3'b101:  ctrl.alu_control = ALU_BGE;
          3'b110:  ctrl.alu_control = ALU_BLTU;
          3'b111:  ctrl.alu_control = ALU_BGEU;
          default: ctrl.alu_control = ALU_ADD;
        endcase
        ctrl.branch = 1'b1;
        imm_src     = IMM_B;
      end
      OP_JAL: begin
        legal           = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      OP_JALR: begin
        legal           = (funct3 == 3'b000);
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OP_LUI: begin
        legal          = 1'b1;
        ctrl.src_a_sel = SRCA_ZERO;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        imm_src        = IMM_U;
      end
      OP_AUIPC: begin
        legal          = 1'b1;
        ctrl.src_a_sel = SRCA_PC;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        imm_src        = IMM_U;
      end
      default: legal = 1'b0;
    endcase

    // Illegal encodings must never change architectural state downstream.
    if (!legal) begin
      ctrl.illegal     = 1'b1;
      ctrl.reg_write   = 1'b0;
      ctrl.mem_write   = 1'b0;
      ctrl.branch      = 1'b0;
      ctrl.jump        = 1'b0;
      ctrl.alu_control = ALU_ADD;
    end

    if (ctrl.rd == 5'd0)
      ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/id_ex_ctrl.sv
// Decode control unit plus ID/EX pipeline register with stall/flush/bubble handling.
// Optional illegal-instruction counter output enabled by IDEX_ILLEGAL_CNT_EN.
module id_ex_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic [2:0]  ImmSrcD,
  output logic [3:0]  ALUControlE,
  output logic [1:0]  SrcASelE,
  output logic        ALUSrcE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        BranchE,
  output logic        JumpE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [2:0]  Funct3E,
  output logic        IllegalE,
  output logic        ValidE
`ifdef IDEX_ILLEGAL_CNT_EN
  ,
  output logic [7:0]  IllegalCnt
`endif
);

  ctrl_t dec_ctrl;
  ctrl_t e_reg;

  id_decode u_decode (
    .instr   (InstrD),
    .ctrl    (dec_ctrl),
    .imm_src (ImmSrcD)
  );

  // Flush outranks stall; an empty D slot loads a bubble rather than its decode.
  always_ff @(posedge clk) begin
    if (rst)
      e_reg <= CTRL_BUBBLE;
    else if (FlushE)
      e_reg <= CTRL_BUBBLE;
    else if (!StallE)
      e_reg <= ValidD ? dec_ctrl : CTRL_BUBBLE;
  end

  assign ALUControlE = e_reg.alu_control;
  assign SrcASelE    = e_reg.src_a_sel;
  assign ALUSrcE     = e_reg.alu_src;
  assign RegWriteE   = e_reg.reg_write;
  assign MemWriteE   = e_reg.mem_write;
  assign ResultSrcE  = e_reg.result_src;
  assign BranchE     = e_reg.branch;
  assign JumpE       = e_reg.jump;
  assign Rs1E        = e_reg.rs1;
  assign Rs2E        = e_reg.rs2;
  assign RdE         = e_reg.rd;
  assign Funct3E     = e_reg.funct3;
  assign IllegalE    = e_reg.illegal;
  assign ValidE      = e_reg.valid;

`ifdef IDEX_ILLEGAL_CNT_EN
  logic [7:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_reg <= '0;
    else if (!FlushE && !StallE && ValidD && dec_ctrl.illegal && cnt_reg != 8'hFF)
      cnt_reg <= cnt_reg + 8'd1;
  end

  assign IllegalCnt = cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Directed bench for id_ex_ctrl: hand-derived expected decodes, a small pipeline-register model and a scoreboard queue.
module tb_id_ex_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] InstrD = 32'h0000_0013;
  logic        ValidD = 1'b0;
  logic        StallE = 1'b0;
  logic        FlushE = 1'b0;
  logic [2:0]  ImmSrcD;
  logic [3:0]  ALUControlE;
  logic [1:0]  SrcASelE;
  logic        ALUSrcE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic [1:0]  ResultSrcE;
  logic        BranchE;
  logic        JumpE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [2:0]  Funct3E;
  logic        IllegalE;
  logic        ValidE;
`ifdef IDEX_ILLEGAL_CNT_EN
  logic [7:0]  IllegalCnt;
`endif

  always #5 clk = ~clk;

  id_ex_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .InstrD      (InstrD),
    .ValidD      (ValidD),
    .StallE      (StallE),
    .FlushE      (FlushE),
    .ImmSrcD     (ImmSrcD),
    .ALUControlE (ALUControlE),
    .SrcASelE    (SrcASelE),
    .ALUSrcE     (ALUSrcE),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .ResultSrcE  (ResultSrcE),
    .BranchE     (BranchE),
    .JumpE       (JumpE),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .Funct3E     (Funct3E),
    .IllegalE    (IllegalE),
    .ValidE      (ValidE)
`ifdef IDEX_ILLEGAL_CNT_EN
    ,
    .IllegalCnt  (IllegalCnt)
`endif
  );

  localparam logic [32:0] BUB = '0;

  localparam logic [31:0] I_SUB   = 32'h40B5_0533;
  localparam logic [31:0] I_OR    = 32'h00B5_6533;
  localparam logic [31:0] I_ADD   = 32'h00B5_0533;
  localparam logic [31:0] I_BNE   = 32'h00B5_1463;
  localparam logic [31:0] I_BBAD  = 32'h00B5_2463;
  localparam logic [31:0] I_SRAI  = 32'h4015_D513;
  localparam logic [31:0] I_SBAD  = 32'h4215_D513;
  localparam logic [31:0] I_LUI   = 32'h1234_52B7;
  localparam logic [31:0] I_AUIPC = 32'h1234_5297;
  localparam logic [31:0] I_JAL0  = 32'h0000_006F;
  localparam logic [31:0] I_LW    = 32'h0005_A503;
  localparam logic [31:0] I_SW    = 32'h00A5_A023;
  localparam logic [31:0] I_JALR  = 32'h0005_00E7;
  localparam logic [31:0] I_UNK   = 32'hFFFF_FFFF;

  int total = 0;
  int bad = 0;
  logic [32:0] sb_q[$];
  logic [32:0] model_e = '0;
  int cnt_model = 0;

  // Field order mirrors the observed vector assembled in step().
  function automatic logic [32:0] pk(input logic [3:0] alu, input logic [1:0] srca,
                                     input logic alusrc, input logic regw, input logic memw,
                                     input logic [1:0] ress, input logic br, input logic jmp,
                                     input logic ill, input logic [31:0] ins);
    return {alu, srca, alusrc, regw, memw, ress, br, jmp,
            ins[19:15], ins[24:20], ins[11:7], ins[14:12], ill, 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic v, input logic s,
                      input logic f, input logic r, input logic [32:0] dec, input logic [2:0] imm_exp);
    logic [32:0] got;
    @(negedge clk);
    InstrD = ins; ValidD = v; StallE = s; FlushE = f; rst = r;
    if (r || f)
      model_e = BUB;
    else if (!s)
      model_e = v ? dec : BUB;
    if (r)
      cnt_model = 0;
    else if (!f && !s && v && dec[1] && cnt_model < 255)
      cnt_model++;
    sb_q.push_back(model_e);
    #1;
    chk({tag, "/imm"}, {30'd0, ImmSrcD}, {30'd0, imm_exp});
    @(posedge clk);
    #1;
    got = {ALUControlE, SrcASelE, ALUSrcE, RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE,
           Rs1E, Rs2E, RdE, Funct3E, IllegalE, ValidE};
    chk(tag, got, sb_q.pop_front());
`ifdef IDEX_ILLEGAL_CNT_EN
    chk({tag, "/cnt"}, {25'd0, IllegalCnt}, 33'(cnt_model));
`endif
    $display("step %s instr=%h e=%h", tag, ins, got);
  endtask

  logic [32:0] d_sub, d_or, d_add, d_bne, d_bbad, d_srai, d_sbad, d_lui, d_auipc;
  logic [32:0] d_jal0, d_lw, d_sw, d_jalr, d_unk;

  initial begin
    d_sub   = pk(4'b0001, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, I_SUB);
    d_or    = pk(4'b0011, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, I_OR);
    d_add   = pk(4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, I_ADD);
    d_bne   = pk(4'b1011, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, I_BNE);
    d_bbad  = pk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, I_BBAD);
    d_srai  = pk(4'b1001, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, I_SRAI);
    d_sbad  = pk(4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, I_SBAD);
    d_lui   = pk(4'b0000, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, I_LUI);
    d_auipc = pk(4'b0000, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, I_AUIPC);
    d_jal0  = pk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, I_JAL0);
    d_lw    = pk(4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, I_LW);
    d_sw    = pk(4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, I_SW);
    d_jalr  = pk(4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, I_JALR);
    d_unk   = pk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, I_UNK);

    repeat (2) @(posedge clk);
    // tag, instr, valid, stall, flush, rst, decode, imm
    step("reset",     I_ADD,   1, 0, 0, 1, d_add,   3'b000);
    step("sub",       I_SUB,   1, 0, 0, 0, d_sub,   3'b000);
    step("or",        I_OR,    1, 0, 0, 0, d_or,    3'b000);
    step("bne",       I_BNE,   1, 0, 0, 0, d_bne,   3'b010);
    step("br_f3_010", I_BBAD,  1, 0, 0, 0, d_bbad,  3'b010);
    step("srai",      I_SRAI,  1, 0, 0, 0, d_srai,  3'b000);
    step("srai_bad",  I_SBAD,  1, 0, 0, 0, d_sbad,  3'b000);
    step("lui",       I_LUI,   1, 0, 0, 0, d_lui,   3'b100);
    step("auipc",     I_AUIPC, 1, 0, 0, 0, d_auipc, 3'b100);
    step("jal_x0",    I_JAL0,  1, 0, 0, 0, d_jal0,  3'b011);
    step("lw",        I_LW,    1, 0, 0, 0, d_lw,    3'b000);
    step("sw",        I_SW,    1, 0, 0, 0, d_sw,    3'b001);
    step("jalr",      I_JALR,  1, 0, 0, 0, d_jalr,  3'b000);
    step("unknown",   I_UNK,   1, 0, 0, 0, d_unk,   3'b000);

    step("add_load",  I_ADD,   1, 0, 0, 0, d_add,   3'b000);
    step("stall1",    I_SUB,   1, 1, 0, 0, d_sub,   3'b000);
    step("stall2",    I_BNE,   1, 1, 0, 0, d_bne,   3'b010);
    step("stall3",    I_SW,    1, 1, 0, 0, d_sw,    3'b001);
    step("stall_fl",  I_OR,    1, 1, 1, 0, d_or,    3'b000);
    step("add_again", I_ADD,   1, 0, 0, 0, d_add,   3'b000);
    step("stall4",    I_LUI,   1, 1, 0, 0, d_lui,   3'b100);
    step("rst_stall", I_LUI,   1, 1, 0, 1, d_lui,   3'b100);
    step("nvalid_il", I_UNK,   0, 0, 0, 0, d_unk,   3'b000);
    step("nvalid_ok", I_JAL0,  0, 0, 0, 0, d_jal0,  3'b011);

    for (int i = 0; i < 5; i++)
      step("ill_cnt", I_UNK, 1, 0, 0, 0, d_unk, 3'b000);
    step("ill_stall", I_BBAD,  1, 1, 0, 0, d_bbad,  3'b010);
    step("ill_flush", I_BBAD,  1, 0, 1, 0, d_bbad,  3'b010);
    step("ill_nval",  I_SBAD,  0, 0, 0, 0, d_sbad,  3'b000);
    for (int i = 0; i < 300; i++)
      step("ill_sat", I_UNK, 1, 0, 0, 0, d_unk, 3'b000);
    step("legal_sat", I_OR,    1, 0, 0, 0, d_or,    3'b000);
    step("rst_end",   I_UNK,   1, 0, 0, 1, d_unk,   3'b000);
    step("after_rst", I_SRAI,  1, 0, 0, 0, d_srai,  3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
